bus_bridge: RTL and testbench

Memory-side bus bridge for the MC6502 core. Sits directly downstream of the datapath's address/data outputs and upstream of its `DB_IN` input. Each core bus cycle, it captures `ABH`/`ABL`/`DB_OUT`/`RW`, runs a req/ack transaction on an external synchronous memory port, and returns read data on `DB_IN`. It then pulses a one-cycle clock-enable so the core advances exactly one bus cycle per completed access.

---
 rtl/bus_bridge_pkg.sv | 13 +
 rtl/bus_wdog.sv | 21 ++
 rtl/bus_bridge.sv | 106 ++++++++++
 tb/tb_bus_bridge.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// bus_bridge_pkg: shared FSM state encodings and RW bus-direction constants for bus_bridge
package bus_bridge_pkg;

    typedef enum logic [1:0] {
        BB_IDLE = 2'd0,
        BB_REQ  = 2'd1,
        BB_STEP = 2'd2
    } bb_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/bus_wdog.sv
// bus_wdog: REQ-phase watchdog counter; clears on clr, counts on en, flags when the limit cycle is reached
module bus_wdog #(
    parameter int P_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RES_N,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RES_N || clr) cnt <= 8'd0;
        else if (en)       cnt <= cnt + 8'd1;
    end

    assign hit = (cnt == 8'(P_TIMEOUT - 1));

endmodule

// File: rtl/bus_bridge.sv
// bus_bridge: MC6502 memory-side bridge, one req/ack access then a one-cycle CORE_CE per core bus cycle.
// Optional REQ timeout with sticky BUS_ERR is built when BUS_BRIDGE_TIMEOUT_EN is defined.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int         P_TIMEOUT = 16,
    parameter logic [7:0] P_DB_INIT = 8'h00
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic [7:0]  ABL,
    input  logic [7:0]  ABH,
    input  logic [7:0]  DB_OUT,
    input  logic        RW,
    output logic [7:0]  DB_IN,
    output logic        CORE_CE,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [7:0]  MEM_WDATA,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA,
    output logic        BUS_ERR
);

    if (P_TIMEOUT < 2 || P_TIMEOUT > 255) $error("bus_bridge: P_TIMEOUT must be 2..255");

    bb_state_t   state, state_d;
    logic [7:0]  db_d, wdata_d;
    logic [15:0] addr_d;
    logic        ce_d, we_d, req_d, to_hit;

`ifdef BUS_BRIDGE_TIMEOUT_EN
    logic hit, err_q;

    bus_wdog #(.P_TIMEOUT(P_TIMEOUT)) u_wdog (
        .CLK   (CLK),
        .RES_N (RES_N),
        .clr   (state == BB_IDLE),
        .en    (state == BB_REQ && !MEM_ACK),
        .hit   (hit)
    );

    // an ack in the limit cycle wins over the timeout
    assign to_hit = hit && !MEM_ACK;

    always_ff @(posedge CLK) begin
        if (!RES_N) err_q <= 1'b0;
        else        err_q <= err_q | (state == BB_REQ && to_hit);
    end

    assign BUS_ERR = err_q;
`else
    assign to_hit  = 1'b0;
    assign BUS_ERR = 1'b0;
`endif

    always_comb begin
        state_d = state;
        db_d    = DB_IN;
        ce_d    = 1'b0;
        addr_d  = MEM_ADDR;
        we_d    = MEM_WE;
        wdata_d = MEM_WDATA;
        req_d   = MEM_REQ;
        case (state)
            BB_IDLE: begin
                addr_d  = {ABH, ABL};
                we_d    = (RW == RW_WRITE);
                wdata_d = DB_OUT;
                req_d   = 1'b1;
                state_d = BB_REQ;
            end
            BB_REQ: begin
                if (MEM_ACK || to_hit) begin
                    db_d    = MEM_ACK ? (MEM_WE ? DB_IN : MEM_RDATA) : 8'hFF;
                    req_d   = 1'b0;
                    ce_d    = 1'b1;
                    state_d = BB_STEP;
                end
            end
            default: state_d = BB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state     <= BB_IDLE;
            DB_IN     <= P_DB_INIT;
            CORE_CE   <= 1'b0;
            MEM_ADDR  <= 16'h0000;
            MEM_WE    <= 1'b0;
            MEM_WDATA <= 8'h00;
            MEM_REQ   <= 1'b0;
        end else begin
            state     <= state_d;
            DB_IN     <= db_d;
            CORE_CE   <= ce_d;
            MEM_ADDR  <= addr_d;
            MEM_WE    <= we_d;
            MEM_WDATA <= wdata_d;
            MEM_REQ   <= req_d;
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
// tb_bus_bridge: directed self-checking bench for bus_bridge (timeout scenarios when BUS_BRIDGE_TIMEOUT_EN is defined)
module tb_bus_bridge;

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic [7:0]  ABL = 8'h00, ABH = 8'h00, DB_OUT = 8'h00;
    logic        RW = 1'b1;
    logic [7:0]  DB_IN;
    logic        CORE_CE;
    logic [15:0] MEM_ADDR;
    logic        MEM_WE;
    logic [7:0]  MEM_WDATA;
    logic        MEM_REQ;
    logic        MEM_ACK = 1'b0;
    logic [7:0]  MEM_RDATA = 8'h00;
    logic        BUS_ERR;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_db;

    bus_bridge #(.P_TIMEOUT(4), .P_DB_INIT(8'h3C)) dut (
        .CLK(CLK), .RES_N(RES_N), .ABL(ABL), .ABH(ABH), .DB_OUT(DB_OUT), .RW(RW),
        .DB_IN(DB_IN), .CORE_CE(CORE_CE), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
        .MEM_WDATA(MEM_WDATA), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK),
        .MEM_RDATA(MEM_RDATA), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RES_N = 1'b0;
        step();
        step();
        n_vec++; if (DB_IN !== 8'h3C) begin n_err++; $display("FAIL reset_db_in got %h want 3c", DB_IN); end
        n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL reset_core_ce got %b want 0", CORE_CE); end
        n_vec++; if (MEM_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr got %h want 0000", MEM_ADDR); end
        n_vec++; if (MEM_WE !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", MEM_WE); end
        n_vec++; if (MEM_WDATA !== 8'h00) begin n_err++; $display("FAIL reset_mem_wdata got %h want 00", MEM_WDATA); end
        n_vec++; if (MEM_REQ !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", MEM_REQ); end
        n_vec++; if (BUS_ERR !== 1'b0) begin n_err++; $display("FAIL reset_bus_err got %b want 0", BUS_ERR); end
        exp_db = 8'h3C;
        RES_N = 1'b1;
    endtask

    task automatic test_zero_wait_read();
        ABH = 8'h12; ABL = 8'h34; RW = 1'b1; MEM_ACK = 1'b0;
        step();
        n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL zr_req_rise got %b want 1", MEM_REQ); end
        n_vec++; if (MEM_ADDR !== 16'h1234) begin n_err++; $display("FAIL zr_addr got %h want 1234", MEM_ADDR); end
        n_vec++; if (MEM_WE !== 1'b0) begin n_err++; $display("FAIL zr_we got %b want 0", MEM_WE); end
        n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL zr_ce_early got %b want 0", CORE_CE); end
        MEM_ACK = 1'b1; MEM_RDATA = 8'hA9; ABH = 8'hFF; ABL = 8'hEE;
        step();
        MEM_ACK = 1'b0; MEM_RDATA = 8'h00;
        exp_db = 8'hA9;
        n_vec++; if (MEM_REQ !== 1'b0) begin n_err++; $display("FAIL zr_req_fall got %b want 0", MEM_REQ); end
        n_vec++; if (CORE_CE !== 1'b1) begin n_err++; $display("FAIL zr_ce_pulse got %b want 1", CORE_CE); end
        n_vec++; if (DB_IN !== exp_db) begin n_err++; $display("FAIL zr_db_in got %h want %h", DB_IN, exp_db); end
        n_vec++; if (MEM_ADDR !== 16'h1234) begin n_err++; $display("FAIL zr_addr_hold got %h want 1234", MEM_ADDR); end
        ABH = 8'h00; ABL = 8'h20;
        step();
        n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL zr_ce_drop got %b want 0", CORE_CE); end
        n_vec++; if (MEM_REQ !== 1'b0) begin n_err++; $display("FAIL zr_idle_req got %b want 0", MEM_REQ); end
        step();
        n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL zr_period3 got %b want 1", MEM_REQ); end
        n_vec++; if (MEM_ADDR !== 16'h0020) begin n_err++; $display("FAIL zr_next_addr got %h want 0020", MEM_ADDR); end
        MEM_ACK = 1'b1; MEM_RDATA = 8'h4B;
        step();
        MEM_ACK = 1'b0;
        exp_db = 8'h4B;
        n_vec++; if (DB_IN !== exp_db) begin n_err++; $display("FAIL zr_second_db got %h want %h", DB_IN, exp_db); end
        step();
    endtask

    task automatic test_write_wait();
        ABH = 8'h00; ABL = 8'h10; DB_OUT = 8'h5A; RW = 1'b0; MEM_ACK = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            DB_OUT = 8'h00; RW = 1'b1;
            n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL wr_req[%0d] got %b want 1", i, MEM_REQ); end
            n_vec++; if (MEM_WE !== 1'b1) begin n_err++; $display("FAIL wr_we[%0d] got %b want 1", i, MEM_WE); end
            n_vec++; if (MEM_WDATA !== 8'h5A) begin n_err++; $display("FAIL wr_wdata[%0d] got %h want 5a", i, MEM_WDATA); end
            n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL wr_ce[%0d] got %b want 0", i, CORE_CE); end
            if (i == 2) begin MEM_ACK = 1'b1; MEM_RDATA = 8'h66; end
        end
        step();
        MEM_ACK = 1'b0;
        n_vec++; if (CORE_CE !== 1'b1) begin n_err++; $display("FAIL wr_ce_pulse got %b want 1", CORE_CE); end
        n_vec++; if (MEM_REQ !== 1'b0) begin n_err++; $display("FAIL wr_req_fall got %b want 0", MEM_REQ); end
        n_vec++; if (DB_IN !== exp_db) begin n_err++; $display("FAIL wr_db_kept got %h want %h", DB_IN, exp_db); end
        step();
        n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL wr_ce_drop got %b want 0", CORE_CE); end
        n_vec++; if (MEM_WE !== 1'b1 || MEM_WDATA !== 8'h5A) begin n_err++; $display("FAIL wr_hold got we=%b wdata=%h want we=1 wdata=5a", MEM_WE, MEM_WDATA); end
    endtask

    task automatic test_spurious_ack();
        ABH = 8'h40; ABL = 8'h00; RW = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 8'h77;
        step();
        MEM_ACK = 1'b0;
        n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL sp_req got %b want 1", MEM_REQ); end
        n_vec++; if (DB_IN !== exp_db) begin n_err++; $display("FAIL sp_idle_db got %h want %h", DB_IN, exp_db); end
        n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL sp_idle_ce got %b want 0", CORE_CE); end
        step();
        n_vec++; if (MEM_REQ !== 1'b1 || CORE_CE !== 1'b0) begin n_err++; $display("FAIL sp_wait got req=%b ce=%b want req=1 ce=0", MEM_REQ, CORE_CE); end
        MEM_ACK = 1'b1; MEM_RDATA = 8'hC3;
        step();
        exp_db = 8'hC3;
        MEM_RDATA = 8'h77;
        n_vec++; if (DB_IN !== exp_db || CORE_CE !== 1'b1) begin n_err++; $display("FAIL sp_done got db=%h ce=%b want db=%h ce=1", DB_IN, CORE_CE, exp_db); end
        step();
        MEM_ACK = 1'b0;
        n_vec++; if (DB_IN !== exp_db) begin n_err++; $display("FAIL sp_step_db got %h want %h", DB_IN, exp_db); end
        n_vec++; if (CORE_CE !== 1'b0 || MEM_REQ !== 1'b0) begin n_err++; $display("FAIL sp_step_seq got ce=%b req=%b want ce=0 req=0", CORE_CE, MEM_REQ); end
    endtask

    task automatic test_reset_mid_req();
        ABH = 8'hAB; ABL = 8'hCD; RW = 1'b1; MEM_ACK = 1'b0;
        step();
        n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL rm_req got %b want 1", MEM_REQ); end
        MEM_ACK = 1'b1; MEM_RDATA = 8'hE7; RES_N = 1'b0;
        step();
        exp_db = 8'h3C;
        n_vec++; if (DB_IN !== exp_db) begin n_err++; $display("FAIL rm_db got %h want %h", DB_IN, exp_db); end
        n_vec++; if (MEM_REQ !== 1'b0 || CORE_CE !== 1'b0) begin n_err++; $display("FAIL rm_ctl got req=%b ce=%b want 0 0", MEM_REQ, CORE_CE); end
        n_vec++; if (MEM_ADDR !== 16'h0000 || MEM_WE !== 1'b0 || MEM_WDATA !== 8'h00) begin n_err++; $display("FAIL rm_bus got addr=%h we=%b wd=%h want 0000 0 00", MEM_ADDR, MEM_WE, MEM_WDATA); end
        RES_N = 1'b1; MEM_ACK = 1'b0; ABH = 8'h22; ABL = 8'h11;
        step();
        n_vec++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 16'h2211) begin n_err++; $display("FAIL rm_first_req got req=%b addr=%h want 1 2211", MEM_REQ, MEM_ADDR); end
        MEM_ACK = 1'b1; MEM_RDATA = 8'h5E;
        step();
        MEM_ACK = 1'b0;
        exp_db = 8'h5E;
        n_vec++; if (DB_IN !== exp_db || CORE_CE !== 1'b1) begin n_err++; $display("FAIL rm_after got db=%h ce=%b want %h 1", DB_IN, CORE_CE, exp_db); end
        step();
    endtask

`ifdef BUS_BRIDGE_TIMEOUT_EN
    task automatic test_ack_at_limit();
        RW = 1'b1; MEM_ACK = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (MEM_REQ !== 1'b1) begin n_err++; $display("FAIL al_req[%0d] got %b want 1", i, MEM_REQ); end
            if (i == 3) begin MEM_ACK = 1'b1; MEM_RDATA = 8'h81; end
        end
        step();
        MEM_ACK = 1'b0;
        exp_db = 8'h81;
        n_vec++; if (DB_IN !== exp_db || CORE_CE !== 1'b1) begin n_err++; $display("FAIL al_done got db=%h ce=%b want %h 1", DB_IN, CORE_CE, exp_db); end
        n_vec++; if (BUS_ERR !== 1'b0) begin n_err++; $display("FAIL al_err got %b want 0", BUS_ERR); end
        step();
    endtask

    task automatic test_timeout();
        RW = 1'b0; DB_OUT = 8'h99; MEM_ACK = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (MEM_REQ !== 1'b1 || CORE_CE !== 1'b0) begin n_err++; $display("FAIL to_req[%0d] got req=%b ce=%b want 1 0", i, MEM_REQ, CORE_CE); end
        end
        step();
        exp_db = 8'hFF;
        n_vec++; if (MEM_REQ !== 1'b0 || CORE_CE !== 1'b1) begin n_err++; $display("FAIL to_end got req=%b ce=%b want 0 1", MEM_REQ, CORE_CE); end
        n_vec++; if (DB_IN !== exp_db || BUS_ERR !== 1'b1) begin n_err++; $display("FAIL to_flag got db=%h err=%b want ff 1", DB_IN, BUS_ERR); end
        step();
        n_vec++; if (CORE_CE !== 1'b0) begin n_err++; $display("FAIL to_ce_once got %b want 0", CORE_CE); end
        RW = 1'b1;
        step();
        MEM_ACK = 1'b1; MEM_RDATA = 8'h12;
        step();
        MEM_ACK = 1'b0;
        exp_db = 8'h12;
        n_vec++; if (DB_IN !== exp_db || BUS_ERR !== 1'b1) begin n_err++; $display("FAIL to_sticky got db=%h err=%b want %h 1", DB_IN, BUS_ERR, exp_db); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait();
        test_spurious_ack();
        test_reset_mid_req();
`ifdef BUS_BRIDGE_TIMEOUT_EN
        test_ack_at_limit();
        test_timeout();
`else
        n_vec++; if (BUS_ERR !== 1'b0) begin n_err++; $display("FAIL no_to_err got %b want 0", BUS_ERR); end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
